// File: rtl/golden_bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// golden_bist_ctrl_if
// Bundles the control/status and datapath-facing signals of the golden BIST
// controller so the controller and its environment connect through one port.
//
// Signals
//   start            1  one-cycle run launch pulse            (env -> ctrl)
//   abort            1  level, terminates a run in progress   (env -> ctrl)
//   dut_data_out     5  result returned by datapath under test (env -> ctrl)
//   dut_data_in      5  pattern driven into the datapath       (ctrl -> env)
//   dut_reset        1  active-high sync clear for datapath    (ctrl -> env)
//   busy             1  high in every state except IDLE        (ctrl -> env)
//   done             1  one-cycle completion pulse             (ctrl -> env)
//   pass             1  run verdict, valid with done           (ctrl -> env)
//   fail_count       6  mismatches in current/last run         (ctrl -> env)
//   first_fail_pat   5  pattern of first mismatch              (ctrl -> env)
//   first_fail_valid 1  a mismatch has been recorded           (ctrl -> env)
//
// Modports
//   master : the BIST controller
//   slave  : the surrounding test environment / datapath wrapper
// -----------------------------------------------------------------------------
interface golden_bist_ctrl_if;
   logic       start;
   logic       abort;
   logic [4:0] dut_data_out;
   logic [4:0] dut_data_in;
   logic       dut_reset;
   logic       busy;
   logic       done;
   logic       pass;
   logic [5:0] fail_count;
   logic [4:0] first_fail_pat;
   logic       first_fail_valid;

   modport master (
      input  start,
      input  abort,
      input  dut_data_out,
      output dut_data_in,
      output dut_reset,
      output busy,
      output done,
      output pass,
      output fail_count,
      output first_fail_pat,
      output first_fail_valid
   );

   modport slave (
      output start,
      output abort,
      output dut_data_out,
      input  dut_data_in,
      input  dut_reset,
      input  busy,
      input  done,
      input  pass,
      input  fail_count,
      input  first_fail_pat,
      input  first_fail_valid
   );
endinterface

// File: rtl/golden_bist_ctrl.sv
// -----------------------------------------------------------------------------
// golden_bist_ctrl
// Built-in self test controller for a 5-bit encode / priority-index datapath.
// A run flushes the datapath, sweeps patterns 0..LAST_PAT one per cycle, and
// compares each returned result against a golden model once the datapath
// latency has elapsed. Mismatches are counted and the first failing pattern
// is recorded.
//
// Parameters
//   LATENCY   clock edges from dut_data_in change to valid dut_data_out
//   LAST_PAT  final pattern applied (0..31)
//
// Ports
//   clk    single clock for the controller (and the datapath in test mode)
//   reset  asynchronous active-low reset
//   bus    golden_bist_ctrl_if.master: start/abort in, datapath result in,
//          pattern / datapath clear / status and result registers out
// -----------------------------------------------------------------------------
module golden_bist_ctrl #(
   parameter int LATENCY  = 2,
   parameter int LAST_PAT = 31
) (
   input logic                clk,
   input logic                reset,
   golden_bist_ctrl_if.master bus
);

   localparam int                CNT_W      = $clog2(LATENCY + 2);
   localparam logic [CNT_W-1:0]  FLUSH_END  = CNT_W'(LATENCY);
   localparam logic [CNT_W-1:0]  DRAIN_END  = CNT_W'(LATENCY - 1);
   localparam logic [4:0]        LAST_PAT_V = 5'(LAST_PAT);

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      DRIVE,
      DRAIN,
      DONE
   } state_t;

   // Golden encoder: identity up to 18, a fixed code for 19, zero above.
   function automatic logic [4:0] enc(input logic [4:0] v);
      if (v <= 5'd18) begin
         enc = v;
      end else if (v == 5'd19) begin
         enc = 5'b10111;
      end else begin
         enc = 5'd0;
      end
   endfunction

   // Index of the highest set bit; both 0 and 1 map to index 0.
   function automatic logic [2:0] msb_idx(input logic [4:0] e);
      msb_idx = 3'd0;
      for (int b = 1; b < 5; b++) begin
         if (e[b]) begin
            msb_idx = 3'(b);
         end
      end
   endfunction

   // Mismatch counter saturates at 32 (the largest possible sweep).
   function automatic logic [5:0] sat_inc(input logic [5:0] c);
      sat_inc = (c >= 6'd32) ? c : c + 6'd1;
   endfunction

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [4:0]         r_dut_data_in;
   logic               r_dut_reset;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;
   logic [5:0]         r_fail_count;
   logic [4:0]         r_first_fail_pat;
   logic               r_first_fail_valid;

   // Tag pipeline: one entry per applied pattern, aligned with the datapath.
   logic [LATENCY-1:0] r_tag_vld_p;
   logic [4:0]         r_tag_pat_p [LATENCY];
   logic [2:0]         r_tag_exp_p [LATENCY];

   logic               w_cmp_state;
   logic               w_mis;
   logic               w_abort;
   logic [5:0]         w_fc_next;

   assign w_cmp_state = (r_state == DRIVE) || (r_state == DRAIN);
   assign w_abort     = bus.abort && (r_state != IDLE);
   assign w_mis       = w_cmp_state && r_tag_vld_p[LATENCY-1] &&
                        (bus.dut_data_out != {2'b00, r_tag_exp_p[LATENCY-1]});
   assign w_fc_next   = w_mis ? sat_inc(r_fail_count) : r_fail_count;

   // ---- tag stage boundary: valid bits (control, reset) ----
   // A tag is launched for each cycle a pattern is on dut_data_in during
   // DRIVE, so the exiting tag lines up with that pattern's result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tag_vld_p <= '0;
      end else if (w_abort) begin
         r_tag_vld_p <= '0;
      end else begin
         r_tag_vld_p[0] <= (r_state == DRIVE);
         for (int i = 1; i < LATENCY; i++) begin
            r_tag_vld_p[i] <= r_tag_vld_p[i-1];
         end
      end
   end

   // ---- tag stage boundary: pattern and expected value (data, no reset) ----
   always_ff @(posedge clk) begin
      r_tag_pat_p[0] <= r_dut_data_in;
      r_tag_exp_p[0] <= msb_idx(enc(r_dut_data_in));
      for (int i = 1; i < LATENCY; i++) begin
         r_tag_pat_p[i] <= r_tag_pat_p[i-1];
         r_tag_exp_p[i] <= r_tag_exp_p[i-1];
      end
   end

   // ---- controller FSM with registered outputs ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state            <= IDLE;
         r_cnt              <= '0;
         r_dut_data_in      <= 5'd0;
         r_dut_reset        <= 1'b1;
         r_busy             <= 1'b0;
         r_done             <= 1'b0;
         r_pass             <= 1'b0;
         r_fail_count       <= 6'd0;
         r_first_fail_pat   <= 5'd0;
         r_first_fail_valid <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // Result capture; an aborting edge discards the in-flight compare.
         if (w_mis && !bus.abort) begin
            r_fail_count <= w_fc_next;
            if (!r_first_fail_valid) begin
               r_first_fail_valid <= 1'b1;
               r_first_fail_pat   <= r_tag_pat_p[LATENCY-1];
            end
         end

         if (w_abort) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_dut_reset   <= 1'b1;
            r_dut_data_in <= 5'd0;
            r_cnt         <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (bus.start) begin
                     r_state            <= FLUSH;
                     r_busy             <= 1'b1;
                     r_dut_reset        <= 1'b1;
                     r_dut_data_in      <= 5'd0;
                     r_cnt              <= '0;
                     r_pass             <= 1'b0;
                     r_fail_count       <= 6'd0;
                     r_first_fail_pat   <= 5'd0;
                     r_first_fail_valid <= 1'b0;
                  end
               end

               // Hold the datapath in clear for LATENCY+1 cycles so every
               // stage is known-zero before the first pattern.
               FLUSH: begin
                  if (r_cnt == FLUSH_END) begin
                     r_state       <= DRIVE;
                     r_dut_reset   <= 1'b0;
                     r_dut_data_in <= 5'd0;
                     r_cnt         <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               // dut_data_in doubles as the pattern counter.
               DRIVE: begin
                  if (r_dut_data_in == LAST_PAT_V) begin
                     r_state       <= DRAIN;
                     r_dut_data_in <= 5'd0;
                     r_cnt         <= '0;
                  end else begin
                     r_dut_data_in <= r_dut_data_in + 5'd1;
                  end
               end

               // LATENCY cycles lets the last tag reach the compare point.
               // pass uses w_fc_next so the final compare is included.
               DRAIN: begin
                  if (r_cnt == DRAIN_END) begin
                     r_state     <= DONE;
                     r_dut_reset <= 1'b1;
                     r_done      <= 1'b1;
                     r_pass      <= (w_fc_next == 6'd0);
                     r_cnt       <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               DONE: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end

               default: begin
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
                  r_dut_reset <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.dut_data_in      = r_dut_data_in;
   assign bus.dut_reset        = r_dut_reset;
   assign bus.busy             = r_busy;
   assign bus.done             = r_done;
   assign bus.pass             = r_pass;
   assign bus.fail_count       = r_fail_count;
   assign bus.first_fail_pat   = r_first_fail_pat;
   assign bus.first_fail_valid = r_first_fail_valid;

endmodule
